// File: rtl/registra_tiros.sv
// registra_tiros
// Shot-registration responder plus shared shot table.
// On a start request, the block captures the ship position and shot direction.
// It then searches the table from slot 0 for the first free slot. If it finds
// one, it writes the shot there. If the table is full, it discards the shot.
// In both cases it pulses fim_registra_tiros for one cycle.
// The movement/collision logic reads slots through the combinational query
// port and frees slots through the release port.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   inicia_registra_tiros        start request (sampled only in inicial)
//   posicao_nave, direcao_tiro   shot data, captured on start
//   libera_tiro, libera_indice   clear the valid bit of a slot at the next edge
//   consulta_indice              query slot select
//   consulta_valido/_posicao/_direcao  query results (combinational)
//   num_tiros_ativos             popcount of the valid bits
//   fim_registra_tiros           one-cycle done pulse
//   tiro_descartado              high while in cheio (table found full)
//   db_estado_registra_tiros     debug state code
module registra_tiros #(
  parameter int N_TIROS = 8,
  parameter int W_IDX   = 3,
  parameter int W_POS   = 8,
  parameter int W_DIR   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inicia_registra_tiros,
  input  logic [W_POS-1:0] posicao_nave,
  input  logic [W_DIR-1:0] direcao_tiro,
  input  logic             libera_tiro,
  input  logic [W_IDX-1:0] libera_indice,
  input  logic [W_IDX-1:0] consulta_indice,
  output logic             consulta_valido,
  output logic [W_POS-1:0] consulta_posicao,
  output logic [W_DIR-1:0] consulta_direcao,
  output logic [W_IDX:0]   num_tiros_ativos,
  output logic             fim_registra_tiros,
  output logic             tiro_descartado,
  output logic [4:0]       db_estado_registra_tiros
);

  typedef enum logic [4:0] {
    INICIAL = 5'b00000,
    BUSCA   = 5'b00001,
    GRAVA   = 5'b00010,
    FIM     = 5'b00011,
    CHEIO   = 5'b00100
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [W_IDX-1:0]   idx_q, idx_d;
  logic [W_POS-1:0]   pos_cap_q, pos_cap_d;
  logic [W_DIR-1:0]   dir_cap_q, dir_cap_d;
  logic [N_TIROS-1:0] valido_q, valido_d;
  logic [W_POS-1:0]   pos_mem_q [N_TIROS];
  logic [W_POS-1:0]   pos_mem_d [N_TIROS];
  logic [W_DIR-1:0]   dir_mem_q [N_TIROS];
  logic [W_DIR-1:0]   dir_mem_d [N_TIROS];

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      idx_q     <= '0;
      pos_cap_q <= '0;
      dir_cap_q <= '0;
      valido_q  <= '0;
      pos_mem_q <= '{default: '0};
      dir_mem_q <= '{default: '0};
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      pos_cap_q <= pos_cap_d;
      dir_cap_q <= dir_cap_d;
      valido_q  <= valido_d;
      pos_mem_q <= pos_mem_d;
      dir_mem_q <= dir_mem_d;
    end
  end

  // Next-state, search pointer and table update.
  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    pos_cap_d = pos_cap_q;
    dir_cap_d = dir_cap_q;
    valido_d  = valido_q;
    pos_mem_d = pos_mem_q;
    dir_mem_d = dir_mem_q;

    case (estado_q)
      INICIAL: begin
        if (inicia_registra_tiros) begin
          estado_d  = BUSCA;
          idx_d     = '0;
          pos_cap_d = posicao_nave;
          dir_cap_d = direcao_tiro;
        end
      end
      BUSCA: begin
        if (!valido_q[idx_q]) begin
          estado_d = GRAVA;
        end else if (idx_q == W_IDX'(N_TIROS - 1)) begin
          estado_d = CHEIO;
        end else begin
          idx_d = idx_q + W_IDX'(1);
        end
      end
      GRAVA:   estado_d = FIM;
      CHEIO:   estado_d = FIM;
      FIM:     estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase

    if (libera_tiro) begin
      valido_d[libera_indice] = 1'b0;
    end

    // The write comes after the release, so the write wins on a same-slot collision.
    if (estado_q == GRAVA) begin
      valido_d[idx_q]  = 1'b1;
      pos_mem_d[idx_q] = pos_cap_q;
      dir_mem_d[idx_q] = dir_cap_q;
    end
  end

  // Moore outputs and debug code.
  always_comb begin
    fim_registra_tiros = 1'b0;
    tiro_descartado    = 1'b0;
    case (estado_q)
      INICIAL: db_estado_registra_tiros = 5'b00000;
      BUSCA:   db_estado_registra_tiros = 5'b00001;
      GRAVA:   db_estado_registra_tiros = 5'b00010;
      FIM: begin
        db_estado_registra_tiros = 5'b00011;
        fim_registra_tiros       = 1'b1;
      end
      CHEIO: begin
        db_estado_registra_tiros = 5'b00100;
        tiro_descartado          = 1'b1;
      end
      default: db_estado_registra_tiros = 5'b01111;
    endcase
  end

  always_comb begin
    num_tiros_ativos = '0;
    for (int unsigned i = 0; i < N_TIROS; i++) begin
      num_tiros_ativos = num_tiros_ativos + (W_IDX + 1)'(valido_q[i]);
    end
  end

  assign consulta_valido  = valido_q[consulta_indice];
  assign consulta_posicao = pos_mem_q[consulta_indice];
  assign consulta_direcao = dir_mem_q[consulta_indice];

endmodule
